// File: rtl/branch_predictor_pkg.sv
// Shared CPU-wide definitions for the branch-direction predictor:
// 2-bit saturating counter encodings and the counter reset value.
package branch_predictor_pkg;

    localparam logic [1:0] SNT = 2'b00;
    localparam logic [1:0] WNT = 2'b01;
    localparam logic [1:0] WT  = 2'b10;
    localparam logic [1:0] ST  = 2'b11;

    localparam logic [1:0] CTR_RESET = WNT;

    // The counter MSB alone carries the predicted direction.
    function automatic logic ctr_predicts_taken(input logic [1:0] ctr);
        return ctr[1];
    endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Combinational next-state function of one 2-bit saturating direction counter.
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  logic [1:0] cur_i,
    input  logic       taken_i,
    output logic [1:0] next_o
);

    // Step toward ST on taken, toward SNT on not-taken, holding at the ends.
    always_comb begin
        next_o = cur_i;
        case (cur_i)
            SNT: begin
                if (taken_i) next_o = WNT;
                else         next_o = SNT;
            end
            WNT: begin
                if (taken_i) next_o = WT;
                else         next_o = SNT;
            end
            WT: begin
                if (taken_i) next_o = ST;
                else         next_o = WNT;
            end
            ST: begin
                if (taken_i) next_o = ST;
                else         next_o = WT;
            end
            default: next_o = CTR_RESET;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal / gshare branch-direction predictor with 2-bit counters,
// training at resolve, mispredict flagging and performance counters.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int PC_WIDTH  = 64,
    parameter int ENTRIES   = 64,
    parameter int GHR_BITS  = 0,
    parameter int CNT_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [PC_WIDTH-1:0]          if_pc,
    output logic                         pred_taken,
    output logic [$clog2(ENTRIES)-1:0]   pred_idx,
    input  logic                         upd_valid,
    input  logic                         upd_branch,
    input  logic                         upd_taken,
    input  logic                         upd_pred,
    input  logic [$clog2(ENTRIES)-1:0]   upd_idx,
    output logic                         mispredict,
    output logic [CNT_WIDTH-1:0]         branch_cnt,
    output logic [CNT_WIDTH-1:0]         mispred_cnt
);

    localparam int IDX_W = $clog2(ENTRIES);

    logic [1:0]           bht_q [ENTRIES];
    logic [IDX_W-1:0]     pc_idx_s;
    logic [IDX_W-1:0]     lookup_idx_s;
    logic                 upd_fire_s;
    logic                 upd_miss_s;
    logic [1:0]           ctr_cur_s;
    logic [1:0]           ctr_next_s;
    logic [CNT_WIDTH-1:0] branch_cnt_q;
    logic [CNT_WIDTH-1:0] branch_cnt_d;
    logic [CNT_WIDTH-1:0] mispred_cnt_q;
    logic [CNT_WIDTH-1:0] mispred_cnt_d;
    logic                 unused_pc_s;

    assign pc_idx_s    = if_pc[IDX_W+1:2];
    assign unused_pc_s = ^{if_pc[PC_WIDTH-1:IDX_W+2], if_pc[1:0]};

    assign upd_fire_s  = upd_valid & upd_branch;
    assign upd_miss_s  = upd_fire_s & (upd_pred != upd_taken);

    generate
        if (GHR_BITS == 0) begin : g_bimodal
            assign lookup_idx_s = pc_idx_s;
        end else begin : g_gshare
            logic [GHR_BITS-1:0] ghr_q;
            logic [GHR_BITS-1:0] ghr_d;
            logic [GHR_BITS-1:0] ghr_shift_s;

            if (GHR_BITS == 1) begin : g_ghr1
                assign ghr_shift_s = upd_taken;
            end else begin : g_ghrn
                assign ghr_shift_s = {ghr_q[GHR_BITS-2:0], upd_taken};
            end

            // Lookup uses the pre-update history; new history lands next cycle.
            assign lookup_idx_s = pc_idx_s ^ IDX_W'(ghr_q);

            // History shifts in each resolved conditional-branch outcome.
            always_comb begin
                ghr_d = ghr_q;
                if (upd_fire_s) begin
                    ghr_d = ghr_shift_s;
                end else begin
                    ghr_d = ghr_q;
                end
            end

            // History register with synchronous active-low reset.
            always_ff @(posedge clk) begin
                if (!rstn) begin
                    ghr_q <= {GHR_BITS{1'b0}};
                end else begin
                    ghr_q <= ghr_d;
                end
            end
        end
    endgenerate

    assign ctr_cur_s = bht_q[upd_idx];

    sat_counter2 u_sat_counter2 (
        .cur_i   (ctr_cur_s),
        .taken_i (upd_taken),
        .next_o  (ctr_next_s)
    );

    // Counter table: register array, all entries reset to weak-not-taken.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < ENTRIES; i++) begin
                bht_q[i] <= CTR_RESET;
            end
        end else if (upd_fire_s) begin
            bht_q[upd_idx] <= ctr_next_s;
        end
    end

    // Performance counters wrap freely modulo 2^CNT_WIDTH.
    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (upd_fire_s) begin
            branch_cnt_d = branch_cnt_q + CNT_WIDTH'(1);
            if (upd_miss_s) begin
                mispred_cnt_d = mispred_cnt_q + CNT_WIDTH'(1);
            end else begin
                mispred_cnt_d = mispred_cnt_q;
            end
        end else begin
            branch_cnt_d  = branch_cnt_q;
            mispred_cnt_d = mispred_cnt_q;
        end
    end

    // Counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            branch_cnt_q  <= {CNT_WIDTH{1'b0}};
            mispred_cnt_q <= {CNT_WIDTH{1'b0}};
        end else begin
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign pred_idx    = lookup_idx_s;
    assign pred_taken  = ctr_predicts_taken(bht_q[lookup_idx_s]);
    assign mispredict  = upd_miss_s;
    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

endmodule
